limn2600_bus_master: RTL

//  Initiator side of the Limn2600 SRAM bus (cs/we/addr/wdata -> rdy/rdata).

---
 rtl/limn2600_bus_pkg.sv | 15 +
 rtl/limn2600_bus_master_if.sv | 35 +++
 rtl/limn2600_bus_timeout.sv | 33 +++
 rtl/limn2600_bus_master.sv | 106 ++++++++++
 4 files changed

// File: rtl/limn2600_bus_pkg.sv
// Limn2600 SRAM bus master: shared types and constants.
// FSM encodings, alignment mask, timeout counter width.
package limn2600_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam logic [1:0] ALIGN_MASK = 2'b11;
  localparam int TO_CNT_W = 16;

endpackage

// File: rtl/limn2600_bus_master_if.sv
// Limn2600 bus master port bundle: CPU request/response
// handshakes plus the SRAM-side strobe bus.
interface limn2600_bus_master_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [31:0]           req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;
  logic                  mem_cs;
  logic                  mem_we;
  logic [31:0]           mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_rdy;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata,
    input  resp_ready, mem_rdy, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_cs, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata,
    output resp_ready, mem_rdy, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_cs, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/limn2600_bus_timeout.sv
// Wait-state watchdog: cleared on strobe, counts while waiting,
// flags expiry on the last permitted wait cycle.
module limn2600_bus_timeout #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  import limn2600_bus_pkg::*;

  localparam logic [TO_CNT_W-1:0] LAST = TO_CNT_W'(LIMIT - 1);

  logic [TO_CNT_W-1:0] cnt_q;
  logic [TO_CNT_W-1:0] cnt_d;

  // next count: clear wins over count
  always_comb begin
    cnt_d = cnt_q;
    if (clr) cnt_d = '0;
    else if (en) cnt_d = cnt_q + 1'b1;
  end

  // counter register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired = en && (cnt_q == LAST);
endmodule

// File: rtl/limn2600_bus_master.sv
// Limn2600 SRAM bus initiator, one outstanding word access.
// Optional wait-state timeout under BUS_TIMEOUT_EN.
module limn2600_bus_master #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic clk,
  input logic rst,
  limn2600_bus_master_if.master bus
);
  import limn2600_bus_pkg::*;

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [31:0]           addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  to_expired;

`ifdef BUS_TIMEOUT_EN
  limn2600_bus_timeout #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_q == ST_ISSUE),
    .en     (state_q == ST_WAIT),
    .expired(to_expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES < 2);
  assign to_expired = 1'b0;
`endif

  // next-state and request/response latching
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (1'b1)
      state_q == ST_IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          if ((bus.req_addr[1:0] & ALIGN_MASK) != 2'b00) begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      state_q == ST_ISSUE: state_d = ST_WAIT;
      state_q == ST_WAIT: begin
        if (bus.mem_rdy) begin
          rdata_d = we_q ? '0 : bus.mem_rdata;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (to_expired) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      state_q == ST_RESP: begin
        if (bus.resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready  = (state_q == ST_IDLE) && !rst;
  assign bus.resp_valid = (state_q == ST_RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign bus.mem_cs     = (state_q == ST_ISSUE);
  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
endmodule
